// File: rtl/aes_arbiter.sv
// aes_arbiter: round-robin front end that shares a single aes_core between
// N requesters. One job at a time: accept with a one-cycle grant, hold the
// core's load line until done or watchdog expiry, then present the response
// until the consumer takes it.
module aes_arbiter #(
  parameter int N       = 4,
  parameter int K       = 128,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*K-1:0]       key_in,
  input  logic [N*128-1:0]     pt_in,
  output logic [N-1:0]         gnt,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [$clog2(N)-1:0] rsp_id,
  output logic [127:0]         rsp_ct,
  output logic                 rsp_err,
  output logic                 core_load,
  output logic [K-1:0]         core_key,
  output logic [127:0]         core_pt,
  input  logic                 core_done,
  input  logic [127:0]         core_ct
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_r;
  logic [IW-1:0]   ptr_r;
  logic [CW-1:0]   cnt_r;
  logic            core_load_r;
  logic            rsp_valid_r;
  logic            rsp_err_r;
  logic [IW-1:0]   rsp_id_r;
  logic [127:0]    rsp_ct_r;
  logic [K-1:0]    core_key_r;
  logic [127:0]    core_pt_r;

  logic [IW-1:0]   sel_s;
  logic [IW-1:0]   idx_s;
  logic            found_s;
  logic            grant_ok_s;
  logic [IW-1:0]   ptr_nxt_s;
  logic            timeout_s;
  logic [N-1:0]    gnt_s;

  // Round-robin pick: first requesting index at or above ptr, wrapping mod N.
  always_comb begin
    sel_s   = '0;
    idx_s   = '0;
    found_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx_s = IW'((int'(ptr_r) + i) % N);
      if (!found_s && req[idx_s]) begin
        found_s = 1'b1;
        sel_s   = idx_s;
      end else begin
        sel_s   = sel_s;
      end
    end
  end

  // A grant needs an idle arbiter, a live request and a re-armed core.
  assign grant_ok_s = (state_r == IDLE) && found_s && !core_done && !reset;
  assign ptr_nxt_s  = IW'((int'(sel_s) + 1) % N);
  assign timeout_s  = (cnt_r == CW'(TIMEOUT - 1));

  // One-hot grant pulse, only in the accepting cycle.
  always_comb begin
    if (grant_ok_s) begin
      gnt_s = N'(1'b1) << sel_s;
    end else begin
      gnt_s = '0;
    end
  end

  // Job sequencer: accept, run the core under the watchdog, hold the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      ptr_r       <= '0;
      cnt_r       <= '0;
      core_load_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_id_r    <= '0;
      rsp_ct_r    <= '0;
      core_key_r  <= '0;
      core_pt_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_ok_s) begin
            core_key_r  <= key_in[int'(sel_s)*K +: K];
            core_pt_r   <= pt_in[int'(sel_s)*128 +: 128];
            rsp_id_r    <= sel_s;
            ptr_r       <= ptr_nxt_s;
            cnt_r       <= '0;
            core_load_r <= 1'b1;
            state_r     <= RUN;
          end else begin
            state_r     <= IDLE;
          end
        end
        RUN: begin
          cnt_r <= cnt_r + CW'(1'b1);
          // done has priority over a watchdog expiry in the same cycle
          if (core_done) begin
            rsp_ct_r    <= core_ct;
            rsp_err_r   <= 1'b0;
            core_load_r <= 1'b0;
            rsp_valid_r <= 1'b1;
            state_r     <= RESP;
          end else if (timeout_s) begin
            rsp_ct_r    <= 128'h0;
            rsp_err_r   <= 1'b1;
            core_load_r <= 1'b0;
            rsp_valid_r <= 1'b1;
            state_r     <= RESP;
          end else begin
            state_r     <= RUN;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r     <= RESP;
          end
        end
        default: begin
          core_load_r <= 1'b0;
          rsp_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_s;
  assign core_load = core_load_r;
  assign core_key  = core_key_r;
  assign core_pt   = core_pt_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_ct    = rsp_ct_r;
  assign rsp_err   = rsp_err_r;

endmodule
